// File: rtl/memory_data_unit_pkg.sv
// Shared CPU-side definitions for the memory data unit: transaction states and widths.
package memory_data_unit_pkg;

    localparam int WORD_W         = 32;
    localparam int DEFAULT_ADDR_W = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } mdu_state_t;

endpackage

// File: rtl/mem_txn_fsm.sv
// Memory transaction controller: state, saturating wait counter, strobes, done pulse and sticky timeout.
module mem_txn_fsm
    import memory_data_unit_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clock,
    input  logic clear,
    input  logic Read,
    input  logic Write,
    input  logic mem_ready,
    output logic mem_rd,
    output logic mem_wr,
    output logic busy,
    output logic done,
    output logic err,
    output logic capture,
    output logic load_ok
);

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    mdu_state_t state, state_next;
    logic [7:0] wait_cnt, wait_next;
    logic       err_next;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
            err      <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            err      <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        err_next   = err;
        case (state)
            IDLE: begin
                // Read has priority; a simultaneous Write is simply dropped
                if (Read) begin
                    state_next = READ;
                    wait_next  = 8'd0;
                    err_next   = 1'b0;
                end else if (Write) begin
                    state_next = WRITE;
                    wait_next  = 8'd0;
                    err_next   = 1'b0;
                end
            end
            READ, WRITE: begin
                if (mem_ready) begin
                    state_next = DONE;
                end else if (wait_cnt == LAST_WAIT) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end else if (wait_cnt != 8'hFF) begin
                    wait_next = wait_cnt + 8'd1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes decode straight from the state register, so reset drops them at once
    always_comb begin
        mem_rd  = (state == READ);
        mem_wr  = (state == WRITE);
        busy    = (state == READ) || (state == WRITE);
        done    = (state == DONE);
        capture = (state == READ) && mem_ready;
        load_ok = (state == IDLE) || (state == DONE);
    end

endmodule

// File: rtl/memory_data_unit.sv
// CPU memory-side datapath: MAR, MDR and their load selection around the transaction controller.
module memory_data_unit
    import memory_data_unit_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [WORD_W-1:0] BusMuxOut,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              Read,
    input  logic              Write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [WORD_W-1:0] Mdatain,
    input  logic              mem_ready,
    output logic [WORD_W-1:0] MDR_q,
    output logic              busy,
    output logic              done,
    output logic              err
);

    logic [ADDR_W-1:0] mar;
    logic [WORD_W-1:0] mdr;
    logic              capture;
    logic              load_ok;
    logic              mar_load;
    logic              mdr_bus_load;

    mem_txn_fsm #(
        .TIMEOUT (TIMEOUT)
    ) fsm (
        .clock     (clock),
        .clear     (clear),
        .Read      (Read),
        .Write     (Write),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .capture   (capture),
        .load_ok   (load_ok)
    );

    // Bus loads are locked out while a strobe is active so address/data stay stable
    assign mar_load     = MARin && load_ok;
    assign mdr_bus_load = MDRin && load_ok;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            mar <= '0;
            mdr <= '0;
        end else begin
            if (mar_load)
                mar <= BusMuxOut[ADDR_W-1:0];
            if (capture)
                mdr <= Mdatain;
            else if (mdr_bus_load)
                mdr <= BusMuxOut;
        end
    end

    assign mem_addr  = mar;
    assign mem_wdata = mdr;
    assign MDR_q     = mdr;

endmodule

// File: tb/tb_memory_data_unit.sv
// Self-checking bench for memory_data_unit: directed scenarios plus randomized transactions vs. a transaction-level model.
module tb_memory_data_unit;

    localparam int ADDR_W  = 9;
    localparam int TIMEOUT = 15;

    logic              clock = 1'b0;
    logic              clear;
    logic [31:0]       BusMuxOut;
    logic              MARin, MDRin, Read, Write;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_rd, mem_wr;
    logic [31:0]       Mdatain;
    logic              mem_ready;
    logic [31:0]       MDR_q;
    logic              busy, done, err;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] m_mar;
    logic [31:0]       m_mdr;

    always #5 clock = ~clock;

    memory_data_unit #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .BusMuxOut (BusMuxOut),
        .MARin     (MARin),
        .MDRin     (MDRin),
        .Read      (Read),
        .Write     (Write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .Mdatain   (Mdatain),
        .mem_ready (mem_ready),
        .MDR_q     (MDR_q),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // A read capture and an honoured bus load of MDR must never land on the same edge
    always @(posedge clock) begin
        if (clear)
            assert (!(dut.capture && dut.mdr_bus_load))
                else $error("capture and MDRin load coincide");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_mar(input logic [31:0] v);
        BusMuxOut = v;
        MARin     = 1'b1;
        @(posedge clock); #1;
        MARin = 1'b0;
        m_mar = v[ADDR_W-1:0];
    endtask

    task automatic load_mdr(input logic [31:0] v);
        BusMuxOut = v;
        MDRin     = 1'b1;
        @(posedge clock); #1;
        MDRin = 1'b0;
        m_mdr = v;
    endtask

    // One transaction from IDLE. nwait >= TIMEOUT means memory never answers.
    task automatic run_txn(input string tag, input bit rd, input bit wr, input int nwait,
                           input logic [31:0] rdata, input bit noise);
        int hi = 0, wrong = 0, bad_addr = 0, bad_data = 0, done_cnt = 0, done_iter = 0;
        bit is_read = rd;
        bit tmo     = (nwait >= TIMEOUT);
        Read  = rd;
        Write = wr;
        @(posedge clock); #1;
        Read  = 1'b0;
        Write = 1'b0;
        check({tag, ":err_cleared"}, err, 0);
        for (int i = 1; i <= TIMEOUT + 5; i++) begin
            if (is_read ? mem_rd : mem_wr) hi++;
            if (is_read ? mem_wr : mem_rd) wrong++;
            if (mem_rd || mem_wr) begin
                if (mem_addr !== m_mar) bad_addr++;
                if (mem_wdata !== m_mdr) bad_data++;
            end
            if (done) begin
                done_cnt++;
                if (done_iter == 0) done_iter = i;
            end
            if (busy) begin
                mem_ready = (i == nwait + 1);
                Mdatain   = rdata;
                if (noise) begin
                    MARin     = 1'($urandom % 2);
                    MDRin     = 1'($urandom % 2);
                    BusMuxOut = $urandom;
                end
            end else begin
                mem_ready = 1'($urandom % 2);
                Mdatain   = $urandom;
                MARin     = 1'b0;
                MDRin     = 1'b0;
            end
            @(posedge clock); #1;
        end
        mem_ready = 1'b0;
        if (is_read && !tmo) m_mdr = rdata;
        check({tag, ":strobe_cycles"}, hi, tmo ? TIMEOUT : nwait + 1);
        check({tag, ":wrong_strobe"}, wrong, 0);
        check({tag, ":addr_stable"}, bad_addr, 0);
        check({tag, ":wdata_stable"}, bad_data, 0);
        check({tag, ":done_count"}, done_cnt, tmo ? 0 : 1);
        check({tag, ":done_latency"}, done_iter, tmo ? 0 : nwait + 2);
        check({tag, ":err"}, err, tmo);
        check({tag, ":mdr"}, MDR_q, m_mdr);
        check({tag, ":mar"}, mem_addr, m_mar);
        check({tag, ":idle"}, busy, 0);
    endtask

    initial begin
        clear = 1'b0; BusMuxOut = '0; MARin = 0; MDRin = 0; Read = 0; Write = 0;
        Mdatain = '0; mem_ready = 0;
        m_mar = '0; m_mdr = '0;
        #1;
        check("rst:mem_rd", mem_rd, 0);
        check("rst:mem_wr", mem_wr, 0);
        check("rst:busy", busy, 0);
        check("rst:done", done, 0);
        check("rst:err", err, 0);
        check("rst:mar", mem_addr, 0);
        check("rst:mdr", MDR_q, 0);
        #20;
        @(negedge clock);
        clear = 1'b1;
        @(posedge clock); #1;

        // Reset during the third wait cycle of a read
        load_mar(32'h0000_01FF);
        load_mdr(32'h1234_5678);
        check("pre:mar", mem_addr, 9'h1FF);
        Read = 1'b1;
        @(posedge clock); #1;
        Read = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("midrst:rd_before", mem_rd, 1);
        clear = 1'b0;
        #1;
        check("midrst:rd_dropped", mem_rd, 0);
        check("midrst:busy", busy, 0);
        check("midrst:done", done, 0);
        check("midrst:err", err, 0);
        check("midrst:mar", mem_addr, 0);
        check("midrst:mdr", MDR_q, 0);
        m_mar = '0; m_mdr = '0;
        @(negedge clock);
        clear = 1'b1;
        @(posedge clock); #1;

        // Zero-wait read
        load_mar(32'h0000_0123);
        check("zw:addr", mem_addr, 9'h123);
        run_txn("zw_read", 1, 0, 0, 32'hDEAD_BEEF, 0);
        check("zw:mdr_const", MDR_q, 32'hDEAD_BEEF);

        // Write with three wait cycles
        load_mdr(32'h0000_00AA);
        run_txn("wr3", 0, 1, 3, 32'h5A5A_5A5A, 0);
        check("wr3:mdr_const", MDR_q, 32'h0000_00AA);

        // Timeout, then a read that clears err
        run_txn("tmo", 1, 0, TIMEOUT, 32'h1111_2222, 0);
        check("tmo:mdr_const", MDR_q, 32'h0000_00AA);
        @(posedge clock); #1;
        check("tmo:err_sticky", err, 1);
        run_txn("after_tmo", 1, 0, 1, 32'hCAFE_F00D, 0);

        // Read+Write together with loads attempted while busy
        run_txn("rw_both", 1, 1, 2, 32'h0BAD_F00D, 1);

        // MAR takes only the low address bits
        load_mar(32'hFFFF_FE05);
        check("mar_trunc", mem_addr, 9'h005);

        for (int n = 0; n < 25; n++) begin
            if ($urandom % 2) load_mar($urandom);
            if ($urandom % 2) load_mdr($urandom);
            case ($urandom % 3)
                0:       run_txn("rnd_rd", 1, 0, int'($urandom_range(0, 18)), $urandom, 1);
                1:       run_txn("rnd_wr", 0, 1, int'($urandom_range(0, 18)), $urandom, 1);
                default: run_txn("rnd_rw", 1, 1, int'($urandom_range(0, 18)), $urandom, 1);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_data_unit.md
# memory_data_unit

- Owns the CPU's memory-side datapath registers: MAR, MDR and a read/write transaction controller.
- Sits between the internal bus (BusMuxOut) and external memory. It drives the address and write data, waits on a ready handshake, and captures read data into MDR.
- MDR_q feeds the bus multiplexer as the MDR source.

## Interface
Parameters:
- ADDR_W, 9: memory address width; MAR takes BusMuxOut[ADDR_W-1:0].
- TIMEOUT, 15: maximum wait cycles for mem_ready before a transaction aborts. Legal range 1–255.

Ports:
- clock  in  1  sole clock, rising edge.
- clear  in  1  asynchronous, active-low reset.
- BusMuxOut  in  32  internal bus value.
- MARin  in  1  load MAR from BusMuxOut.
- MDRin  in  1  load MDR from BusMuxOut.
- Read  in  1  request memory read.
- Write  in  1  request memory write.
- mem_addr  out  ADDR_W  memory address; always equals MAR.
- mem_wdata  out  32  write data; always equals MDR.
- mem_rd  out  1  read strobe, registered.
- mem_wr  out  1  write strobe, registered.
- Mdatain  in  32  memory read data.
- mem_ready  in  1  memory completes the current strobe.
- MDR_q  out  32  MDR contents, to the bus mux.
- busy  out  1  transaction in progress (state READ or WRITE).
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky timeout flag.

## Operation
- **States:** IDLE, READ, WRITE, DONE.
- **IDLE:**
  - Read=1 → READ.
  - Write=1 (with Read=0) → WRITE.
  - Read and Write both high → Read wins; Write is dropped.
  - Accepting a request clears err and loads wait_cnt=0.
- **READ:**
  - mem_rd=1.
  - mem_ready=1 → MDR<=Mdatain, go to DONE.
  - Otherwise wait_cnt++.
- **WRITE:**
  - mem_wr=1, with mem_addr=MAR and mem_wdata=MDR.
  - mem_ready=1 → DONE.
  - Otherwise wait_cnt++.
- **Timeout:** in READ or WRITE with wait_cnt==TIMEOUT-1 and mem_ready=0 → IDLE, err<=1, MDR unchanged, done stays 0.
- **DONE:**
  - done=1 for exactly one cycle, then → IDLE.
  - Requests presented in DONE are ignored; they must be held or re-presented in IDLE.
- **MARin / MDRin:**
  - Honoured only in IDLE and DONE; ignored while busy, so address and data stay stable during a strobe.
  - A READ completion in the same cycle as MDRin: the memory capture wins (cannot coincide by rule above; assert it in the bench).
- **Arithmetic:** wait_cnt is 8-bit, unsigned, saturating. The MAR load truncates the bus to ADDR_W bits, with no sign handling.

## Timing
- **Reset (clear=0, asynchronous):**
  - state=IDLE.
  - MAR=0, MDR=0, wait_cnt=0.
  - mem_rd=0, mem_wr=0, busy=0, done=0, err=0.
  - Reset mid-transaction drops the strobe immediately, without waiting for a clock edge.
- **Request timing:** a request sampled at edge E0 puts the strobe high after E0.
- **Zero-wait memory (mem_ready=1 at E1):**
  - The strobe is high for exactly one cycle.
  - MDR is valid after E1.
  - done is high between E1 and E2.
  - IDLE is reached at E2, so the next request is accepted at E2.
- **N wait cycles:** the strobe is high for N+1 cycles, and the total latency from request to done is N+2 cycles.
- **mem_ready outside READ/WRITE:** ignored.
- **Timeout:** the strobe is high for exactly TIMEOUT cycles, then drops. err rises the same edge the strobe falls.

## Structure
- **Shared CPU package:**
  - The state enum (mdu_state_t: IDLE, READ, WRITE, DONE).
  - Constants WORD_W=32 and default ADDR_W.
- **Sub-module:** one natural split is mem_txn_fsm, holding state, wait counter and strobe/done/err generation.
- **Top level:** holds the MAR and MDR registers and the MDR input select (Mdatain on read completion, BusMuxOut on MDRin).

## Test plan
- **Reset mid-read:** Read with mem_ready held 0, then clear=0 in the 3rd wait cycle → mem_rd drops asynchronously; all outputs are 0 after reset.
- **Zero-wait read:** MARin with BusMuxOut=32'h0000_0123, then Read, with Mdatain=32'hDEAD_BEEF and mem_ready=1 → mem_addr=9'h123, mem_rd high 1 cycle, MDR_q=32'hDEADBEEF, done pulse 2 edges after Read.
- **Write with 3 wait cycles:** MDRin with 32'h0000_00AA, then Write, mem_ready high on the 4th strobe cycle → mem_wr high 4 cycles, mem_wdata=32'hAA throughout, done 1 cycle, MDR unchanged.
- **Timeout (TIMEOUT=15):** Read with mem_ready never high → mem_rd high exactly 15 cycles, err=1, done never pulses, MDR keeps 32'h0000_00AA. The next Read clears err.
- **Simultaneous Read+Write plus busy-time loads:** Read and Write high together, plus MDRin/MARin pulses during busy → only a read occurs; MAR and MDR ignore the busy-time loads; no mem_wr ever asserts.
